// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and helpers for the FIR tap-programming path.
//   state_t        : loader state machine encoding
//   checksum_width : width of the optional load checksum (tap width + log2 taps),
//                    wide enough that summing every tap of a full load cannot
//                    overflow before the modulo wrap.
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [2:0] {
        SM_IDLE,
        SM_FLUSH,
        SM_PREFETCH,
        SM_STREAM,
        SM_WAIT_DONE
    } state_t;

    function automatic int checksum_width(input int tap_width, input int num_taps_log2);
        return tap_width + num_taps_log2;
    endfunction

endpackage

// File: rtl/fir_tap_loader_ram.sv
// -----------------------------------------------------------------------------
// fir_tap_loader_ram
// Simple dual-port coefficient RAM: one synchronous write port, one synchronous
// read port with 1-cycle latency (read data registered on the clock edge that
// samples i_rd_addr). Contents are never reset.
// Ports:
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address, sampled every cycle
//   o_rd_data : registered read data
// -----------------------------------------------------------------------------
module fir_tap_loader_ram #(
    parameter int G_ADDR_WIDTH = 4,
    parameter int G_DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [G_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [G_DATA_WIDTH-1:0] i_wr_data,
    input  logic [G_ADDR_WIDTH-1:0] i_rd_addr,
    output logic [G_DATA_WIDTH-1:0] o_rd_data
);

    logic [G_DATA_WIDTH-1:0] r_mem [0:(2**G_ADDR_WIDTH)-1];
    logic [G_DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fir_tap_loader.sv
// -----------------------------------------------------------------------------
// fir_tap_loader
// Transmit end of the FIR tap-programming interface. A host fills a local
// coefficient RAM; on start the loader drops fir_enable for G_FLUSH_CYCLES to
// restart the FIR, streams taps 0..T-1 with a valid/ready handshake, then waits
// for fir_tap_done (or times out).
// Optional feature macro: FIR_TAP_LOADER_CHECKSUM_EN -- when defined, checksum
// accumulates the sign-extended handshaked taps of each load; otherwise 0.
// Ports:
//   clk, reset (async, active-high)
//   cfg_wr_addr/cfg_wr_data/cfg_wr_en : host RAM write port (idle only)
//   cfg_wr_drop    : 1-cycle pulse when a host write is discarded
//   start          : load request, sampled in SM_IDLE only
//   busy/done/error: status (done/error sticky until next accepted start)
//   fir_enable     : FIR enable
//   tap_dout/tap_dout_valid/tap_dout_ready : tap stream to the FIR
//   fir_tap_done   : FIR load-complete indication
//   checksum       : optional load checksum
// -----------------------------------------------------------------------------
module fir_tap_loader
    import fir_pkg::*;
#(
    parameter int G_NUM_TAPS_LOG2 = 4,
    parameter int G_TAP_WIDTH     = 16,
    parameter int G_FLUSH_CYCLES  = 2,
    parameter int G_DONE_TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
    input  logic                       cfg_wr_en,
    output logic                       cfg_wr_drop,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       fir_enable,
    output logic [G_TAP_WIDTH-1:0]     tap_dout,
    output logic                       tap_dout_valid,
    input  logic                       tap_dout_ready,
    input  logic                       fir_tap_done,
    output logic [checksum_width(G_TAP_WIDTH, G_NUM_TAPS_LOG2)-1:0] checksum
);

    localparam int AW  = G_NUM_TAPS_LOG2;
    localparam int TW  = G_TAP_WIDTH;
    localparam int CW  = checksum_width(G_TAP_WIDTH, G_NUM_TAPS_LOG2);
    localparam int FCW = (G_FLUSH_CYCLES > 1) ? $clog2(G_FLUSH_CYCLES) : 1;
    localparam int TCW = (G_DONE_TIMEOUT > 0) ? $clog2(G_DONE_TIMEOUT + 1) : 1;

    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(G_FLUSH_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST    = TCW'(G_DONE_TIMEOUT);
    localparam logic [AW-1:0]  TAP_LAST   = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic            r_wr_drop;
    logic            r_fir_enable;
    logic [TW-1:0]   r_tap_dout;
    logic            r_tap_valid;
    logic [FCW-1:0]  r_flush_cnt;
    logic [TCW-1:0]  r_to_cnt;
    logic [AW-1:0]   r_rd_ptr;    // address whose word currently sits on w_rd_data
    logic [AW-1:0]   r_tap_idx;   // index of the tap currently on tap_dout
    logic [AW-1:0]   w_rd_addr;
    logic [TW-1:0]   w_rd_data;
    logic            w_hs;
    logic            w_ram_we;
    logic            w_start_acc;

    assign w_hs        = r_tap_valid && tap_dout_ready;
    assign w_ram_we    = cfg_wr_en && (r_state == SM_IDLE);
    assign w_start_acc = start && (r_state == SM_IDLE);

    fir_tap_loader_ram #(
        .G_ADDR_WIDTH (AW),
        .G_DATA_WIDTH (TW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (cfg_wr_addr),
        .i_wr_data (cfg_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read address is speculative: it re-reads the pending word while stalled
    // and jumps ahead on a handshake so back-to-back handshakes see fresh data.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_addr   = r_rd_ptr;
        unique case (r_state)
            SM_IDLE: begin
                if (start) begin
                    w_state_nxt = SM_FLUSH;
                end
            end
            SM_FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_rd_addr   = '0;
                    w_state_nxt = SM_PREFETCH;
                end
            end
            SM_PREFETCH: begin
                w_rd_addr   = AW'(1);
                w_state_nxt = SM_STREAM;
            end
            SM_STREAM: begin
                if (w_hs) begin
                    w_rd_addr = r_rd_ptr + AW'(1);
                    if (r_tap_idx == TAP_LAST) begin
                        w_state_nxt = SM_WAIT_DONE;
                    end
                end
            end
            SM_WAIT_DONE: begin
                if (fir_tap_done || (r_to_cnt == TO_LAST)) begin
                    w_state_nxt = SM_IDLE;
                end
            end
            default: w_state_nxt = SM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_wr_drop    <= 1'b0;
            r_fir_enable <= 1'b0;
            r_tap_dout   <= '0;
            r_tap_valid  <= 1'b0;
            r_flush_cnt  <= '0;
            r_to_cnt     <= '0;
            r_rd_ptr     <= '0;
            r_tap_idx    <= '0;
        end else begin
            r_wr_drop <= cfg_wr_en && (r_state != SM_IDLE);
            unique case (r_state)
                SM_IDLE: begin
                    if (start) begin
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_fir_enable <= 1'b0;
                        r_flush_cnt  <= '0;
                    end
                end
                SM_FLUSH: begin
                    if (r_flush_cnt == FLUSH_LAST) begin
                        r_fir_enable <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FCW'(1);
                    end
                end
                SM_PREFETCH: begin
                    r_tap_dout  <= w_rd_data;
                    r_tap_valid <= 1'b1;
                    r_rd_ptr    <= AW'(1);
                    r_tap_idx   <= '0;
                end
                SM_STREAM: begin
                    if (w_hs) begin
                        r_tap_dout <= w_rd_data;
                        r_rd_ptr   <= r_rd_ptr + AW'(1);
                        r_tap_idx  <= r_tap_idx + AW'(1);
                        if (r_tap_idx == TAP_LAST) begin
                            r_tap_valid <= 1'b0;
                            r_to_cnt    <= '0;
                        end
                    end
                end
                SM_WAIT_DONE: begin
                    if (fir_tap_done) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_error      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_fir_enable <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    logic [CW-1:0] r_checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_hs) begin
            r_checksum <= r_checksum + {{AW{r_tap_dout[TW-1]}}, r_tap_dout};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = CW'(0);
`endif

    assign cfg_wr_drop    = r_wr_drop;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign fir_enable     = r_fir_enable;
    assign tap_dout       = r_tap_dout;
    assign tap_dout_valid = r_tap_valid;

endmodule

// File: tb/tb_fir_tap_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_tap_loader
// Directed bench for fir_tap_loader with a tap scoreboard: expected taps are
// queued when a load is started and popped by a monitor at each handshake.
// -----------------------------------------------------------------------------
module tb_fir_tap_loader;

    localparam int NL  = 4;
    localparam int TW  = 16;
    localparam int T   = 16;
    localparam int FL  = 2;
    localparam int TO  = 15;
    localparam int CW  = TW + NL;

    logic          clk;
    logic          reset;
    logic [NL-1:0] cfg_wr_addr;
    logic [TW-1:0] cfg_wr_data;
    logic          cfg_wr_en;
    logic          cfg_wr_drop;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic          fir_enable;
    logic [TW-1:0] tap_dout;
    logic          tap_dout_valid;
    logic          tap_dout_ready;
    logic          fir_tap_done;
    logic [CW-1:0] checksum;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;
    logic [TW-1:0] exp_q[$];
    bit            prev_stall = 1'b0;
    logic [TW-1:0] prev_data  = '0;

`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    localparam logic [CW-1:0] EXP_SUM = CW'(136);
`else
    localparam logic [CW-1:0] EXP_SUM = CW'(0);
`endif

    fir_tap_loader #(
        .G_NUM_TAPS_LOG2 (NL),
        .G_TAP_WIDTH     (TW),
        .G_FLUSH_CYCLES  (FL),
        .G_DONE_TIMEOUT  (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_wr_drop    (cfg_wr_drop),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .fir_enable     (fir_enable),
        .tap_dout       (tap_dout),
        .tap_dout_valid (tap_dout_valid),
        .tap_dout_ready (tap_dout_ready),
        .fir_tap_done   (fir_tap_done),
        .checksum       (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: scoreboard pop plus stall-hold check, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_stall) begin
            checks++;
            assert (tap_dout_valid === 1'b1 && tap_dout === prev_data) else begin
                failures++;
                $error("FAIL stall_hold observed valid=%b data=%h expected valid=1 data=%h",
                       tap_dout_valid, tap_dout, prev_data);
            end
        end
        prev_stall = (tap_dout_valid === 1'b1) && (tap_dout_ready === 1'b0) && (reset === 1'b0);
        prev_data  = tap_dout;
        if (tap_dout_valid === 1'b1 && tap_dout_ready === 1'b1 && reset === 1'b0) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_tap observed=%h expected=none", tap_dout);
            end
            if (exp_q.size() > 0) begin
                logic [TW-1:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (tap_dout === e) else begin
                    failures++;
                    $error("FAIL tap_order observed=%h expected=%h", tap_dout, e);
                end
            end
            hs_count++;
        end
    end

    task automatic push_taps();
        for (int i = 0; i < T; i++) exp_q.push_back(TW'(i + 1));
        hs_count = 0;
    endtask

    // Called at posedge+1; start is sampled on the next edge.
    task automatic do_start();
        int lat;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_fir_enable_low", 32'(fir_enable), 32'd0);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_error_clr", 32'(error), 32'd0);
        while (tap_dout_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_valid_latency", 32'(lat), 32'(FL + 2));
        chk("fir_enable_at_valid", 32'(fir_enable), 32'd1);
    endtask

    // Returns at posedge+1 of the edge on which handshake n completes.
    task automatic wait_hs(input int n, input bit toggle);
        int budget;
        budget = 400;
        while (hs_count < n && budget > 0) begin
            @(posedge clk); #1;
            if (toggle) tap_dout_ready = ~tap_dout_ready;
            budget--;
        end
        chk("wait_handshakes", 32'(hs_count >= n), 32'd1);
    endtask

    task automatic finish_load();
        fir_tap_done = 1'b1;
        @(posedge clk); #1;
        fir_tap_done = 1'b0;
        chk("load_done", 32'(done), 32'd1);
        chk("load_busy_clr", 32'(busy), 32'd0);
        chk("load_error", 32'(error), 32'd0);
        chk("load_fir_enable", 32'(fir_enable), 32'd1);
        chk("load_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("load_hs_count", 32'(hs_count), 32'(T));
    endtask

    initial begin
        int k;
        reset          = 1'b1;
        cfg_wr_addr    = '0;
        cfg_wr_data    = '0;
        cfg_wr_en      = 1'b0;
        start          = 1'b0;
        tap_dout_ready = 1'b0;
        fir_tap_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_fir_enable", 32'(fir_enable), 32'd0);
        chk("rst_valid", 32'(tap_dout_valid), 32'd0);
        chk("rst_tap_dout", 32'(tap_dout), 32'd0);
        chk("rst_wr_drop", 32'(cfg_wr_drop), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;

        // Fill RAM with 1..16 while idle.
        for (int i = 0; i < T; i++) begin
            @(posedge clk); #1;
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = NL'(i);
            cfg_wr_data = TW'(i + 1);
        end
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        chk("idle_write_no_drop", 32'(cfg_wr_drop), 32'd0);

        // Load with ready held high.
        tap_dout_ready = 1'b1;
        push_taps();
        do_start();
        wait_hs(T, 1'b0);
        finish_load();
        chk("checksum_full", 32'(checksum), 32'(EXP_SUM));

        // Load with ready toggling.
        tap_dout_ready = 1'b0;
        push_taps();
        do_start();
        wait_hs(T, 1'b1);
        finish_load();

        // Host write during streaming is dropped.
        tap_dout_ready = 1'b0;
        push_taps();
        do_start();
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = NL'(3);
        cfg_wr_data = 16'hBEEF;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        chk("drop_pulse", 32'(cfg_wr_drop), 32'd1);
        @(posedge clk); #1;
        chk("drop_one_cycle", 32'(cfg_wr_drop), 32'd0);
        tap_dout_ready = 1'b1;
        wait_hs(T, 1'b0);
        finish_load();

        // Missing done: timeout (also re-reads address 3 unchanged).
        push_taps();
        do_start();
        wait_hs(T, 1'b0);
        k = 0;
        while (error !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'(TO + 1));
        chk("timeout_done", 32'(done), 32'd0);
        chk("timeout_fir_enable", 32'(fir_enable), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);

        // Start pulse during streaming is ignored.
        push_taps();
        do_start();
        wait_hs(6, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_hs(T, 1'b0);
        finish_load();
        repeat (4) @(posedge clk);
        #1;
        chk("restart_ignored_hs", 32'(hs_count), 32'(T));
        chk("restart_ignored_busy", 32'(busy), 32'd0);
        chk("restart_ignored_valid", 32'(tap_dout_valid), 32'd0);
        chk("restart_ignored_done", 32'(done), 32'd1);

        // Reset after the 5th handshake, then a clean reload.
        push_taps();
        do_start();
        wait_hs(5, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(tap_dout_valid), 32'd0);
        chk("midrst_tap_dout", 32'(tap_dout), 32'd0);
        chk("midrst_fir_enable", 32'(fir_enable), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_checksum", 32'(checksum), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        push_taps();
        do_start();
        wait_hs(T, 1'b0);
        finish_load();
        chk("reload_checksum", 32'(checksum), 32'(EXP_SUM));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_tap_loader.md
Name: fir_tap_loader

Overview:
Drives the tap-programming port of configurable_fir, acting as the transmit end of the tap_din / tap_din_valid / tap_din_ready / tap_din_done interface.
- Holds a local coefficient RAM that a host fills through a simple write port.
- On a start pulse: restarts the FIR through its enable input, streams every coefficient in linear order, then waits for the FIR's done indication.
- Reports busy, done and error status back to the host.

Parameters:
- G_NUM_TAPS_LOG2, 4: log2 of the total tap count T = 2**G_NUM_TAPS_LOG2. Must equal the FIR's G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2.
- G_TAP_WIDTH, 16: coefficient width in bits.
- G_FLUSH_CYCLES, 2: number of cycles fir_enable is held low before each load; minimum 1.
- G_DONE_TIMEOUT, 15: cycles allowed between the last tap handshake and fir_tap_done before error is raised.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-high reset.
- cfg_wr_addr, input, G_NUM_TAPS_LOG2: coefficient RAM write address.
- cfg_wr_data, input, G_TAP_WIDTH: coefficient write data.
- cfg_wr_en, input, 1: write strobe.
- cfg_wr_drop, output, 1: one-cycle pulse when a write is discarded because the block is busy.
- start, input, 1: load request, sampled only in SM_IDLE.
- busy, output, 1: high from the accepted start until return to SM_IDLE.
- done, output, 1: sticky; set on successful load, cleared by the next accepted start.
- error, output, 1: sticky; set on timeout, cleared by the next accepted start.
- fir_enable, output, 1: drives the FIR enable input.
- tap_dout, output, G_TAP_WIDTH: connects to FIR tap_din.
- tap_dout_valid, output, 1: connects to FIR tap_din_valid.
- tap_dout_ready, input, 1: from FIR tap_din_ready.
- fir_tap_done, input, 1: from FIR tap_din_done.
- checksum, output, G_TAP_WIDTH+G_NUM_TAPS_LOG2: see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state=SM_IDLE; busy, done, error, cfg_wr_drop, tap_dout_valid, fir_enable = 0; tap_dout = 0; checksum = 0; all counters 0.
- Reset mid-load: immediate return to the reset state above. fir_enable dropping to 0 forces the FIR back to its own init state. RAM contents are not cleared.
- Coefficient RAM: T x G_TAP_WIDTH, synchronous write, synchronous read with 1-cycle latency.
  - Host writes are accepted only in SM_IDLE.
  - cfg_wr_en in any other state asserts cfg_wr_drop for one cycle and leaves the RAM unchanged.
- SM_IDLE:
  - fir_enable keeps its last value (1 after any load, 0 after reset).
  - start=1 moves to SM_FLUSH: busy<=1, done<=0, error<=0, fir_enable<=0, flush counter<=0.
  - cfg_wr_en together with start in the same cycle: the write is performed and the start is taken.
- SM_FLUSH:
  - Hold fir_enable=0 for G_FLUSH_CYCLES cycles, then fir_enable<=1.
  - Issue the RAM read of address 0, go to SM_PREFETCH.
- SM_PREFETCH (1 cycle): load the RAM output into tap_dout, tap_dout_valid<=1, issue the read of address 1, go to SM_STREAM.
- SM_STREAM:
  - A handshake occurs when tap_dout_valid && tap_dout_ready.
  - tap_dout and tap_dout_valid stay stable until the handshake.
  - On each handshake: tap_dout<=next prefetched word, read address advances, tap index increments.
  - Back-to-back handshakes sustain 1 tap per cycle, so the read must be issued speculatively and the address advanced on the handshake.
  - Word order is address 0 first up to T-1, matching the FIR's bank/address split of its program counter.
  - On the handshake of index T-1: tap_dout_valid<=0, timeout counter<=0, go to SM_WAIT_DONE.
  - tap_dout_ready high while tap_dout_valid=0 has no effect.
- SM_WAIT_DONE:
  - fir_tap_done=1 → done<=1, busy<=0, go to SM_IDLE. The FIR raises done one cycle after the last handshake, so the nominal wait is 1 cycle.
  - Timeout counter reaching G_DONE_TIMEOUT first → error<=1, busy<=0, fir_enable<=0, go to SM_IDLE.
  - fir_tap_done observed in any other state is ignored.
- Start while busy: ignored.
- Latency: start to first tap_dout_valid = G_FLUSH_CYCLES+2 cycles. The FIR needs 1 further cycle after enable before it raises ready.
- No arithmetic on tap data; the checksum sum wraps modulo 2**(G_TAP_WIDTH+G_NUM_TAPS_LOG2).

Optional Feature:
- FIR_TAP_LOADER_CHECKSUM_EN defined:
  - checksum accumulates the sign-extended value of each handshaked tap during a load.
  - It is cleared on the accepted start and holds its final value in SM_IDLE.
- Not defined: checksum is tied to 0 and no accumulator is synthesised.

Decomposition:
- Shared package fir_pkg:
  - state_t enum (SM_IDLE, SM_FLUSH, SM_PREFETCH, SM_STREAM, SM_WAIT_DONE);
  - a localparam function for the checksum width.
- One sub-module, fir_tap_loader_ram: simple dual-port, 1-cycle read, same port style as the FIR's internal BRAM.

Test Plan:
- Write taps 0x0001..0x0010 (T=16), pulse start with tap_dout_ready held high → 16 consecutive handshakes in address order, fir_tap_done after the last, then done=1, busy=0; with checksum enabled, checksum=0x0088.
- Same load with tap_dout_ready toggling 1-0-1-0 → tap_dout stable during stalls, all 16 values delivered in order with no duplicates.
- Never assert fir_tap_done → error=1 exactly G_DONE_TIMEOUT+1 cycles after the last handshake, done=0, fir_enable=0, busy=0.
- cfg_wr_en to address 3 with 0xBEEF during SM_STREAM → cfg_wr_drop pulses for 1 cycle; the next load still emits the original address-3 value.
- Assert reset after the 5th handshake → all outputs are 0 immediately; a fresh start then delivers all 16 taps from address 0.
- Pulse start during SM_STREAM → ignored; exactly 16 handshakes occur and done is set once.
